// File: rtl/instruction_sequencer.sv
// Program-buffer instruction sequencer: loads a program through a write port, then
// issues one instruction per clock to the cpu, with HALT and tensor-core WAIT support.
module instruction_sequencer #(
    parameter int          DEPTH           = 64,
    parameter int          ADDR_W          = 6,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000,
    parameter logic [7:0]  HALT_OPCODE     = 8'hFF,
    parameter logic [7:0]  WAIT_OPCODE     = 8'hFE,
    parameter int          TIMEOUT         = 256
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              program_write_enable_in,
    input  logic [ADDR_W-1:0] program_write_address_in,
    input  logic [31:0]       program_write_data_in,
    input  logic              start_in,
    input  logic              tensor_core_done_in,
    output logic [31:0]       current_instruction_out,
    output logic              instruction_valid_out,
    output logic [ADDR_W-1:0] program_counter_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              timeout_error_out,
    output logic [1:0]        debug_state_out
);

    localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0]  LAST_PC    = ADDR_W'(DEPTH - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               pending_q, pending_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timeout_q, timeout_d;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] fetch_w;
    logic        write_ok;
    logic        at_end;

    assign fetch_w  = mem_q[pc_q];
    assign at_end   = (pc_q == LAST_PC);
    assign write_ok = program_write_enable_in && (state_q == ST_IDLE || state_q == ST_DONE);

    always_ff @(posedge clock_in) begin
        if (write_ok) begin
            mem_q[program_write_address_in] <= program_write_data_in;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instr_q   <= NOP_INSTRUCTION;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    // Issue side: instruction_valid_out is a one-cycle qualifier; the cpu must take the
    // word in the cycle it is valid, there is no backpressure and NOP fills every gap.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = NOP_INSTRUCTION;
        valid_d   = 1'b0;
        pending_d = pending_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_in) begin
                    state_d   = ST_RUN;
                    pc_d      = '0;
                    pending_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_RUN: begin
                pending_d = pending_q | tensor_core_done_in;
                if (fetch_w[7:0] == HALT_OPCODE) begin
                    state_d = ST_DONE;
                end else if (fetch_w[7:0] == WAIT_OPCODE) begin
                    if (pending_q || tensor_core_done_in) begin
                        pending_d = 1'b0;
                    end else begin
                        timer_d = '0;
                        state_d = ST_WAIT;
                    end
                    if (at_end) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end else begin
                    instr_d = fetch_w;
                    valid_d = 1'b1;
                    if (at_end) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                // A completion pulse on the final timer cycle still counts as success.
                if (tensor_core_done_in) begin
                    state_d = ST_RUN;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        current_instruction_out = instr_q;
        instruction_valid_out   = valid_q;
        program_counter_out     = pc_q;
        timeout_error_out       = timeout_q;
        busy_out                = (state_q == ST_RUN) || (state_q == ST_WAIT);
        done_out                = (state_q == ST_DONE);
        debug_state_out         = state_q;
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: issued words are checked by a scoreboard
// monitor; state, pc and flags are checked at hand-computed cycles.
module tb_instruction_sequencer;

    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 8;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] waddr = '0;
    logic [31:0]       wdata = '0;
    logic              start = 1'b0;
    logic              tdone = 1'b0;
    logic [31:0]       out_w;
    logic              valid_o;
    logic [ADDR_W-1:0] pc_o;
    logic              busy_o;
    logic              done_o;
    logic              terr_o;
    logic [1:0]        state_o;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int n_checks = 0;
    int n_fail   = 0;

    instruction_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock_in                 (clk),
        .reset_in                 (rst),
        .program_write_enable_in  (we),
        .program_write_address_in (waddr),
        .program_write_data_in    (wdata),
        .start_in                 (start),
        .tensor_core_done_in      (tdone),
        .current_instruction_out  (out_w),
        .instruction_valid_out    (valid_o),
        .program_counter_out      (pc_o),
        .busy_out                 (busy_o),
        .done_out                 (done_o),
        .timeout_error_out        (terr_o),
        .debug_state_out          (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid issue pops one expected word.
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got %h, expected no issue", out_w);
            end else begin
                mon_exp = exp_q.pop_front();
                check("issue_word", out_w, mon_exp);
            end
        end
    end

    task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic pulse_tdone();
        @(negedge clk); tdone = 1'b1;
        @(posedge clk); #1; tdone = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk); rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1; rst = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen = 1'b1;
        end
        check(name, {31'b0, seen}, 32'd1);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_out"},   out_w, 32'h0);
        check({tag, "_valid"}, {31'b0, valid_o}, 32'd0);
        check({tag, "_busy"},  {31'b0, busy_o}, 32'd0);
        check({tag, "_done"},  {31'b0, done_o}, 32'd0);
        check({tag, "_pc"},    {26'b0, pc_o}, 32'd0);
        check({tag, "_terr"},  {31'b0, terr_o}, 32'd0);
        check({tag, "_state"}, {30'b0, state_o}, {30'b0, S_IDLE});
    endtask

    initial begin
        // Reset
        do_reset(2);
        @(negedge clk);
        check_idle_reset("reset");

        // Linear program
        load(6'd0, 32'h0102_0300);
        load(6'd1, 32'h0203_0001);
        load(6'd2, 32'h0000_00FF);
        exp_q.push_back(32'h0102_0300);
        exp_q.push_back(32'h0203_0001);
        pulse_start();
        @(negedge clk); check("lin_busy", {31'b0, busy_o}, 32'd1);
        @(negedge clk); check("lin_valid0", {31'b0, valid_o}, 32'd1);
        @(negedge clk); check("lin_valid1", {31'b0, valid_o}, 32'd1);
        @(negedge clk);
        check("lin_done", {31'b0, done_o}, 32'd1);
        check("lin_nop", out_w, 32'h0);
        check("lin_valid_end", {31'b0, valid_o}, 32'd0);
        check("lin_pc", {26'b0, pc_o}, 32'd2);
        check("lin_drained", exp_q.size(), 0);

        // WAIT resumes on a pulse landing on the last timer cycle
        load(6'd0, 32'h0000_00FE);
        load(6'd1, 32'h0500_0006);
        load(6'd2, 32'h0000_00FF);
        exp_q.push_back(32'h0500_0006);
        pulse_start();
        @(negedge clk); check("wt_run", {30'b0, state_o}, {30'b0, S_RUN});
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            @(negedge clk);
            check("wt_stall_state", {30'b0, state_o}, {30'b0, S_WAIT});
            check("wt_stall_busy", {31'b0, busy_o}, 32'd1);
            check("wt_stall_nop", out_w, 32'h0);
        end
        pulse_tdone();
        @(negedge clk);
        check("wt_resume_state", {30'b0, state_o}, {30'b0, S_RUN});
        check("wt_resume_valid", {31'b0, valid_o}, 32'd0);
        @(negedge clk); check("wt_issue_valid", {31'b0, valid_o}, 32'd1);
        @(negedge clk);
        check("wt_done", {31'b0, done_o}, 32'd1);
        check("wt_no_terr", {31'b0, terr_o}, 32'd0);
        check("wt_pc", {26'b0, pc_o}, 32'd2);
        check("wt_drained", exp_q.size(), 0);

        // Early pulse consumed by the first WAIT, second WAIT times out
        load(6'd0, 32'h0000_1111);
        load(6'd1, 32'h0000_00FE);
        load(6'd2, 32'h0000_2222);
        load(6'd3, 32'h0000_00FE);
        load(6'd4, 32'h0000_00FF);
        exp_q.push_back(32'h0000_1111);
        exp_q.push_back(32'h0000_2222);
        pulse_start();
        pulse_tdone();
        @(negedge clk); check("early_valid0", {31'b0, valid_o}, 32'd1);
        @(negedge clk);
        check("early_no_stall", {30'b0, state_o}, {30'b0, S_RUN});
        check("early_pc", {26'b0, pc_o}, 32'd2);
        @(negedge clk); check("early_valid2", {31'b0, valid_o}, 32'd1);
        @(negedge clk); check("to_enter_wait", {30'b0, state_o}, {30'b0, S_WAIT});
        for (int i = 1; i < TIMEOUT; i++) begin
            @(negedge clk);
            check("to_still_wait", {30'b0, state_o}, {30'b0, S_WAIT});
        end
        @(negedge clk);
        check("to_done", {31'b0, done_o}, 32'd1);
        check("to_terr", {31'b0, terr_o}, 32'd1);
        check("to_pc", {26'b0, pc_o}, 32'd4);
        check("to_drained", exp_q.size(), 0);

        // Restart clears the error, then reset lands during WAIT
        exp_q.push_back(32'h0000_1111);
        pulse_start();
        @(negedge clk);
        check("rs_terr_clear", {31'b0, terr_o}, 32'd0);
        check("rs_done_clear", {31'b0, done_o}, 32'd0);
        @(negedge clk);
        @(negedge clk); check("rs_in_wait", {30'b0, state_o}, {30'b0, S_WAIT});
        do_reset(1);
        @(negedge clk);
        check_idle_reset("rst_wait");

        // Replay from address 0 with both WAITs resolved by pulses
        exp_q.push_back(32'h0000_1111);
        exp_q.push_back(32'h0000_2222);
        pulse_start();
        @(negedge clk);
        @(negedge clk); check("rp_first", {31'b0, valid_o}, 32'd1);
        @(negedge clk); check("rp_wait1", {30'b0, state_o}, {30'b0, S_WAIT});
        pulse_tdone();
        @(negedge clk);
        @(negedge clk); check("rp_second", {31'b0, valid_o}, 32'd1);
        @(negedge clk); check("rp_wait2", {30'b0, state_o}, {30'b0, S_WAIT});
        pulse_tdone();
        @(negedge clk);
        @(negedge clk);
        check("rp_done", {31'b0, done_o}, 32'd1);
        check("rp_pc", {26'b0, pc_o}, 32'd4);
        check("rp_no_terr", {31'b0, terr_o}, 32'd0);
        check("rp_drained", exp_q.size(), 0);

        // Full buffer without HALT, with writes attempted mid-run
        for (int i = 0; i < DEPTH; i++) begin
            load(ADDR_W'(i), 32'h5A00_0000 | (32'(i) << 8) | 32'(i));
            exp_q.push_back(32'h5A00_0000 | (32'(i) << 8) | 32'(i));
        end
        pulse_start();
        load(6'd5, 32'h0000_00FF);
        load(6'd40, 32'hDEAD_BEEF);
        wait_done(DEPTH + 10, "full_done");
        check("full_pc", {26'b0, pc_o}, 32'd63);
        @(negedge clk);
        check("full_valid_end", {31'b0, valid_o}, 32'd0);
        check("full_pc_hold", {26'b0, pc_o}, 32'd63);
        check("full_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
